console_input_arbiter: RTL and testbench

CONSOLE_INPUT_ARBITER -- requirements
Module: console_input_arbiter

---
 rtl/console_input_arbiter_pkg.sv | 29 ++
 rtl/console_input_arbiter_if.sv | 26 ++
 rtl/console_input_arbiter_char_fifo.sv | 63 ++++++
 rtl/console_input_arbiter.sv | 107 ++++++++++
 tb/tb_console_input_arbiter.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/console_input_arbiter_pkg.sv
// Shared console definitions: source identifiers, output FSM encodings,
// and the key/char/command codes used by the console input path.
package console_input_arbiter_pkg;

   // Source identifiers carried on outSrc
   localparam logic SRC_UART = 1'b0;
   localparam logic SRC_KBD  = 1'b1;

   // Output register FSM encodings
   localparam logic [0:0] ST_EMPTY  = 1'b0;
   localparam logic [0:0] ST_LOADED = 1'b1;

   // Character and command codes shared by both decoders
   localparam logic [7:0] CHR_BS       = 8'h08;
   localparam logic [7:0] CHR_LF       = 8'h0A;
   localparam logic [7:0] CHR_CR       = 8'h0D;
   localparam logic [7:0] CHR_ESC      = 8'h1B;
   localparam logic [7:0] CMD_CUR_UP   = 8'h80;
   localparam logic [7:0] CMD_CUR_DOWN = 8'h81;
   localparam logic [7:0] CMD_CUR_LEFT = 8'h82;
   localparam logic [7:0] CMD_CUR_RGHT = 8'h83;

   // One granted byte together with where it came from
   typedef struct packed {
      logic [7:0] data;
      logic       src;
   } out_beat_t;

endpackage

// File: rtl/console_input_arbiter_if.sv
// Bundle of the arbiter's input strobes, output handshake and overflow counters.
interface console_input_arbiter_if #(
   parameter int OVF_W = 8
);
   logic             uartValid;
   logic [7:0]       uartData;
   logic             kbdValid;
   logic [7:0]       kbdData;
   logic             outValid;
   logic [7:0]       outData;
   logic             outSrc;
   logic             outReady;
   logic             ovfClr;
   logic [OVF_W-1:0] uartOvfCnt;
   logic [OVF_W-1:0] kbdOvfCnt;

   modport slave (
      input  uartValid, uartData, kbdValid, kbdData, outReady, ovfClr,
      output outValid, outData, outSrc, uartOvfCnt, kbdOvfCnt
   );

   modport master (
      output uartValid, uartData, kbdValid, kbdData, outReady, ovfClr,
      input  outValid, outData, outSrc, uartOvfCnt, kbdOvfCnt
   );
endinterface

// File: rtl/console_input_arbiter_char_fifo.sv
// Small show-ahead character FIFO: head entry is visible on rdata whenever
// not empty; empty/full reflect occupancy at the start of the cycle.
module char_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 8
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         push,
   input  logic [W-1:0] wdata,
   input  logic         pop,
   output logic         empty,
   output logic         full,
   output logic [W-1:0] rdata
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [AW:0]  wr_ptr_q, wr_ptr_d;
   logic [AW:0]  rd_ptr_q, rd_ptr_d;
   logic [W-1:0] mem_q [DEPTH];
   logic [W-1:0] mem_d [DEPTH];
   logic         do_push, do_pop;

   // Extra pointer bit distinguishes full from empty when indices match
   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

   // Next pointers and storage contents
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) begin
         mem_d[wr_ptr_q[AW-1:0]] = wdata;
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
   end

   // Pointers reset to empty; storage carries no reset
   always_ff @(posedge clk) begin
      if (!resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Character storage update
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/console_input_arbiter.sv
// Merges the UART and keyboard character streams into one console-writer
// stream: per-source FIFOs, round-robin grant into a single output register,
// and saturating per-source drop counters.
module console_input_arbiter
   import console_input_arbiter_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int OVF_W      = 8
) (
   input logic                   clk,
   input logic                   resetn,
   console_input_arbiter_if.slave bus
);
   logic [0:0]       state_q, state_d;
   logic [7:0]       out_data_q, out_data_d;
   logic             out_src_q, out_src_d;
   logic             rr_q, rr_d;
   logic [OVF_W-1:0] uart_ovf_q, uart_ovf_d;
   logic [OVF_W-1:0] kbd_ovf_q, kbd_ovf_d;

   logic             u_empty, u_full, u_pop;
   logic             k_empty, k_full, k_pop;
   logic [7:0]       u_rdata, k_rdata;
   logic             out_free, grant, grant_src;

   function automatic logic [OVF_W-1:0] sat_inc(input logic [OVF_W-1:0] v);
      return (&v) ? v : v + {{(OVF_W-1){1'b0}}, 1'b1};
   endfunction

   char_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_uart_fifo (
      .clk(clk), .resetn(resetn),
      .push(bus.uartValid), .wdata(bus.uartData), .pop(u_pop),
      .empty(u_empty), .full(u_full), .rdata(u_rdata)
   );

   char_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_kbd_fifo (
      .clk(clk), .resetn(resetn),
      .push(bus.kbdValid), .wdata(bus.kbdData), .pop(k_pop),
      .empty(k_empty), .full(k_full), .rdata(k_rdata)
   );

   // Output register can take a new byte when idle or being drained this cycle
   assign out_free = (state_q == ST_EMPTY) || bus.outReady;
   assign u_pop    = grant && (grant_src == SRC_UART);
   assign k_pop    = grant && (grant_src == SRC_KBD);

   // Grant selection and output FSM: sole non-empty source wins, else pointer decides
   always_comb begin
      state_d    = state_q;
      out_data_d = out_data_q;
      out_src_d  = out_src_q;
      rr_d       = rr_q;
      grant_src  = rr_q;
      if (u_empty) begin
         grant_src = SRC_KBD;
      end else if (k_empty) begin
         grant_src = SRC_UART;
      end
      grant = out_free && !(u_empty && k_empty);
      if (grant) begin
         state_d    = ST_LOADED;
         out_data_d = (grant_src == SRC_KBD) ? k_rdata : u_rdata;
         out_src_d  = grant_src;
         rr_d       = ~grant_src;
      end else if (out_free) begin
         state_d    = ST_EMPTY;
      end
   end

   // Drop counters: a strobe against a full FIFO counts; clear overrides a drop
   always_comb begin
      uart_ovf_d = uart_ovf_q;
      kbd_ovf_d  = kbd_ovf_q;
      if (bus.uartValid && u_full) uart_ovf_d = sat_inc(uart_ovf_q);
      if (bus.kbdValid && k_full)  kbd_ovf_d  = sat_inc(kbd_ovf_q);
      if (bus.ovfClr) begin
         uart_ovf_d = '0;
         kbd_ovf_d  = '0;
      end
   end

   // State, output register, pointer and counters
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q    <= ST_EMPTY;
         out_data_q <= 8'h00;
         out_src_q  <= SRC_UART;
         rr_q       <= SRC_UART;
         uart_ovf_q <= '0;
         kbd_ovf_q  <= '0;
      end else begin
         state_q    <= state_d;
         out_data_q <= out_data_d;
         out_src_q  <= out_src_d;
         rr_q       <= rr_d;
         uart_ovf_q <= uart_ovf_d;
         kbd_ovf_q  <= kbd_ovf_d;
      end
   end

   assign bus.outValid   = (state_q == ST_LOADED);
   assign bus.outData    = out_data_q;
   assign bus.outSrc     = out_src_q;
   assign bus.uartOvfCnt = uart_ovf_q;
   assign bus.kbdOvfCnt  = kbd_ovf_q;

endmodule

// File: tb/tb_console_input_arbiter.sv
// Bench for console_input_arbiter: per-source expected-byte queues filled as
// strobes are driven, drained as transfers appear, plus a table of cycle
// vectors and hand-written corner-case sequences.
module tb_console_input_arbiter;
   import console_input_arbiter_pkg::*;

   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic resetn;
   always #5 clk = ~clk;

   console_input_arbiter_if #(.OVF_W(8)) bus();

   console_input_arbiter #(.FIFO_DEPTH(DEPTH), .OVF_W(8)) dut (
      .clk(clk), .resetn(resetn), .bus(bus)
   );

   typedef struct {
      bit         rst;
      bit         uv;
      logic [7:0] ud;
      bit         kv;
      logic [7:0] kd;
      bit         rdy;
      bit         ev;
      logic [7:0] ed;
      logic       es;
   } vec_t;

   vec_t       tbl [13];
   logic [7:0] uq[$];
   logic [7:0] kq[$];
   int         n_chk = 0;
   int         n_pass = 0;
   int         xfers = 0;
   int         exp_u = 0, exp_k = 0, nxt_u = 0, nxt_k = 0;
   int         xb;

   function automatic int sat(input int v);
      return (v >= 255) ? 255 : v + 1;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
   endtask

   // One clock cycle: drive, update model, check at negedge, advance to posedge+1
   task automatic step(input bit uv, input logic [7:0] ud, input bit kv, input logic [7:0] kd,
                       input bit rdy, input bit clr, input bit rst);
      int occ;
      bus.uartValid = uv; bus.uartData = ud;
      bus.kbdValid  = kv; bus.kbdData  = kd;
      bus.outReady  = rdy; bus.ovfClr = clr;
      resetn = ~rst;
      nxt_u = exp_u; nxt_k = exp_k;
      if (!rst) begin
         if (uv) begin
            occ = uq.size() - ((bus.outValid && bus.outSrc == SRC_UART) ? 1 : 0);
            if (occ >= DEPTH) nxt_u = sat(exp_u); else uq.push_back(ud);
         end
         if (kv) begin
            occ = kq.size() - ((bus.outValid && bus.outSrc == SRC_KBD) ? 1 : 0);
            if (occ >= DEPTH) nxt_k = sat(exp_k); else kq.push_back(kd);
         end
         if (clr) begin nxt_u = 0; nxt_k = 0; end
      end
      @(negedge clk);
      chk("uart_ovf_cnt", bus.uartOvfCnt, exp_u);
      chk("kbd_ovf_cnt", bus.kbdOvfCnt, exp_k);
      if (resetn && bus.outValid && bus.outReady) begin
         xfers++;
         if (bus.outSrc == SRC_UART) begin
            if (uq.size() == 0) begin
               n_chk++;
               $display("FAIL unexpected_uart_byte: actual=%0h required=none", bus.outData);
            end else chk("uart_byte", bus.outData, uq.pop_front());
         end else begin
            if (kq.size() == 0) begin
               n_chk++;
               $display("FAIL unexpected_kbd_byte: actual=%0h required=none", bus.outData);
            end else chk("kbd_byte", bus.outData, kq.pop_front());
         end
      end
      @(posedge clk); #1;
      if (rst) begin
         uq.delete(); kq.delete(); exp_u = 0; exp_k = 0;
      end else begin
         exp_u = nxt_u; exp_k = nxt_k;
      end
   endtask

   task automatic idle(input int n, input bit rdy);
      repeat (n) step(1'b0, 8'h00, 1'b0, 8'h00, rdy, 1'b0, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      //            rst uv ud     kv kd     rdy ev ed     es
      tbl[0]  = '{0, 1, 8'h41, 0, 8'h00, 1, 0, 8'h00, 0};
      tbl[1]  = '{0, 0, 8'h00, 0, 8'h00, 1, 0, 8'h00, 0};
      tbl[2]  = '{0, 0, 8'h00, 0, 8'h00, 1, 1, 8'h41, 0};
      tbl[3]  = '{0, 0, 8'h00, 0, 8'h00, 1, 0, 8'h00, 0};
      tbl[4]  = '{1, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0};
      tbl[5]  = '{0, 1, 8'h01, 1, 8'h81, 0, 0, 8'h00, 0};
      tbl[6]  = '{0, 1, 8'h02, 1, 8'h82, 0, 0, 8'h00, 0};
      tbl[7]  = '{0, 0, 8'h00, 0, 8'h00, 0, 1, 8'h01, 0};
      tbl[8]  = '{0, 0, 8'h00, 0, 8'h00, 1, 1, 8'h01, 0};
      tbl[9]  = '{0, 0, 8'h00, 0, 8'h00, 1, 1, 8'h81, 1};
      tbl[10] = '{0, 0, 8'h00, 0, 8'h00, 1, 1, 8'h02, 0};
      tbl[11] = '{0, 0, 8'h00, 0, 8'h00, 1, 1, 8'h82, 1};
      tbl[12] = '{0, 0, 8'h00, 0, 8'h00, 1, 0, 8'h00, 0};

      bus.uartValid = 0; bus.uartData = 0; bus.kbdValid = 0; bus.kbdData = 0;
      bus.outReady = 0; bus.ovfClr = 0; resetn = 0;
      @(posedge clk); #1;
      repeat (2) step(0, 8'h00, 0, 8'h00, 0, 0, 1);

      chk("reset_outValid", bus.outValid, 0);
      chk("reset_outData", bus.outData, 8'h00);
      chk("reset_outSrc", bus.outSrc, 0);
      chk("reset_uartOvf", bus.uartOvfCnt, 0);
      chk("reset_kbdOvf", bus.kbdOvfCnt, 0);

      // Latency of a single byte and round-robin ordering of preloaded FIFOs
      for (int i = 0; i < 13; i++) begin
         chk($sformatf("vec%0d_outValid", i), bus.outValid, tbl[i].ev);
         if (tbl[i].ev) begin
            chk($sformatf("vec%0d_outData", i), bus.outData, tbl[i].ed);
            chk($sformatf("vec%0d_outSrc", i), bus.outSrc, tbl[i].es);
         end
         step(tbl[i].uv, tbl[i].ud, tbl[i].kv, tbl[i].kd, tbl[i].rdy, 1'b0, tbl[i].rst);
      end

      // Held byte stays stable under backpressure, then transfers exactly once
      step(1, 8'h55, 0, 8'h00, 0, 0, 0);
      idle(1, 0);
      for (int i = 0; i < 10; i++) begin
         chk("hold_outValid", bus.outValid, 1);
         chk("hold_outData", bus.outData, 8'h55);
         chk("hold_outSrc", bus.outSrc, SRC_UART);
         idle(1, 0);
      end
      xb = xfers;
      idle(1, 1);
      idle(3, 0);
      chk("hold_single_xfer", xfers - xb, 1);
      chk("hold_after_outValid", bus.outValid, 0);

      // Keyboard overflow with the output register stalled, then saturation and clear
      step(1, 8'h66, 0, 8'h00, 0, 0, 0);
      idle(1, 0);
      chk("stall_outData", bus.outData, 8'h66);
      for (int i = 0; i < 6; i++) step(0, 8'h00, 1, 8'(8'h90 + i), 0, 0, 0);
      chk("kbd_ovf_two", bus.kbdOvfCnt, 2);
      for (int i = 0; i < 300; i++) step(0, 8'h00, 1, 8'hA0, 0, 0, 0);
      chk("kbd_ovf_sat", bus.kbdOvfCnt, 255);
      step(0, 8'h00, 1, 8'hA1, 0, 1, 0);
      chk("kbd_ovf_clr_wins", bus.kbdOvfCnt, 0);
      idle(8, 1);
      chk("drain_outValid", bus.outValid, 0);

      // Strobe on a full UART FIFO while it pops is still dropped
      for (int i = 0; i < 5; i++) step(1, 8'(8'hB0 + i), 0, 8'h00, 0, 0, 0);
      idle(1, 0);
      step(1, 8'hC5, 0, 8'h00, 1, 0, 0);
      chk("uart_drop_on_pop", bus.uartOvfCnt, 1);
      idle(6, 1);
      chk("uart_drain_outValid", bus.outValid, 0);

      // Reset while loaded with both FIFOs holding data, strobes during reset
      step(1, 8'hD0, 1, 8'hE0, 0, 0, 0);
      step(1, 8'hD1, 1, 8'hE1, 0, 0, 0);
      idle(1, 0);
      chk("pre_reset_outValid", bus.outValid, 1);
      step(1, 8'hF0, 1, 8'hF1, 1, 0, 1);
      chk("mid_reset_outValid", bus.outValid, 0);
      chk("mid_reset_outData", bus.outData, 8'h00);
      chk("mid_reset_outSrc", bus.outSrc, 0);
      for (int i = 0; i < 10; i++) begin
         chk("post_reset_outValid", bus.outValid, 0);
         idle(1, 1);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
